// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter for the 64x32 data memory, with a
// sequencer that sweeps zeros through the whole array on init_start.
module mem_arbiter (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  input  logic [1:0]       req_we,
  input  logic [1:0][5:0]  req_addr,
  input  logic [1:0][31:0] req_wdata,
  output logic [1:0]       req_ready,
  output logic [1:0]       resp_valid,
  output logic [31:0]      resp_rdata,
  input  logic             init_start,
  output logic             init_busy,
  output logic             mem_w_en,
  output logic [5:0]       mem_addr,
  output logic [31:0]      mem_w_data,
  input  logic [31:0]      mem_r_data
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        last_grant_q, last_grant_d;
  logic [1:0]  resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;

  logic        gnt;
  logic        accept;

  always_comb begin
    // Tie goes to whoever did not win last; otherwise the lone requester.
    if (&req_valid) gnt = ~last_grant_q;
    else            gnt = ~req_valid[0];

    accept       = (state_q == IDLE) && !init_start && (|req_valid);
    req_ready    = 2'b00;
    if (accept) req_ready[gnt] = 1'b1;

    mem_w_en     = 1'b0;
    mem_addr     = 6'd0;
    mem_w_data   = 32'd0;
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    resp_valid_d = 2'b00;
    resp_rdata_d = resp_rdata_q;

    case (state_q)
      IDLE: begin
        if (init_start) begin
          state_d = CLEAR;
          cnt_d   = 6'd0;
        end else if (accept) begin
          mem_w_en             = req_we[gnt];
          mem_addr             = req_addr[gnt];
          mem_w_data           = req_we[gnt] ? req_wdata[gnt] : 32'd0;
          last_grant_d         = gnt;
          resp_valid_d[gnt]    = 1'b1;
          if (!req_we[gnt]) resp_rdata_d = mem_r_data;
        end
      end
      CLEAR: begin
        mem_w_en   = 1'b1;
        mem_addr   = cnt_q;
        mem_w_data = 32'd0;
        // Counter wraps 63->0 on exit so the next sweep starts at 0.
        cnt_d      = cnt_q + 6'd1;
        if (cnt_q == 6'd63) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 6'd0;
      last_grant_q <= 1'b1;
      resp_valid_q <= 2'b00;
      resp_rdata_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign init_busy  = (state_q == CLEAR);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural memory, reference copy of memory contents
// and a response scoreboard filled on every accept.
module tb_mem_arbiter;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req_valid, req_we;
  logic [1:0][5:0]  req_addr;
  logic [1:0][31:0] req_wdata;
  logic [1:0]       req_ready, resp_valid;
  logic [31:0]      resp_rdata;
  logic             init_start, init_busy;
  logic             mem_w_en;
  logic [5:0]       mem_addr;
  logic [31:0]      mem_w_data, mem_r_data;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0]  id_oh;
    logic [31:0] data;
  } exp_t;
  exp_t        sb[$];
  logic [31:0] ref_mem [64];
  logic [31:0] last_rd;
  logic [31:0] mem [64];

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .init_start(init_start), .init_busy(init_busy),
    .mem_w_en(mem_w_en), .mem_addr(mem_addr), .mem_w_data(mem_w_data),
    .mem_r_data(mem_r_data)
  );

  // Memory with its own reset to zero.
  assign mem_r_data = mem[mem_addr];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'd0;
    end else if (mem_w_en) begin
      mem[mem_addr] <= mem_w_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: each accept must answer on exactly the next cycle.
  initial begin
    exp_t e;
    int   g;
    forever begin
      @(negedge clk);
      if (reset) begin
        sb.delete();
        last_rd = 32'd0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'd0;
      end else begin
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("resp_valid", {30'd0, resp_valid}, {30'd0, e.id_oh});
          chk("resp_rdata", resp_rdata, e.data);
        end else if (resp_valid != 2'b00) begin
          chk("resp_spurious", {30'd0, resp_valid}, 32'd0);
        end
        if (init_start) begin
          for (int i = 0; i < 64; i++) ref_mem[i] = 32'd0;
        end
        if ((req_valid & req_ready) != 2'b00) begin
          g       = req_ready[1] ? 1 : 0;
          e.id_oh = req_ready;
          if (req_we[g]) begin
            e.data = last_rd;
            ref_mem[req_addr[g]] = req_wdata[g];
          end else begin
            e.data  = ref_mem[req_addr[g]];
            last_rd = e.data;
          end
          sb.push_back(e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input int id, input logic we, input logic [5:0] a,
                        input logic [31:0] d, input string tag);
    logic ok;
    req_we[id]    = we;
    req_addr[id]  = a;
    req_wdata[id] = d;
    req_valid[id] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready[id]) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk(tag, {31'd0, ok}, 32'd1);
    tick();
    req_valid[id] = 1'b0;
  endtask

  // Follows a sweep already started; optionally re-pulses init_start mid-sweep.
  task automatic sweep(input int restart_at, output int busy_n, output int rdy_seen,
                       output int bad);
    busy_n = 0; rdy_seen = 0; bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!init_busy) break;
      if (!(mem_w_en && mem_w_data == 32'd0 && mem_addr == busy_n[5:0])) bad++;
      if (req_ready != 2'b00) rdy_seen++;
      busy_n++;
      tick();
      init_start = (restart_at > 0) && (busy_n == restart_at);
    end
  endtask

  initial begin
    int busy_n, rdy_seen, bad, nrdy;
    reset = 1'b1; init_start = 1'b0;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_resp_valid", {30'd0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_init_busy", {31'd0, init_busy}, 32'd0);
    chk("rst_mem_w_en", {31'd0, mem_w_en}, 32'd0);
    chk("rst_mem_addr", {26'd0, mem_addr}, 32'd0);
    tick();
    reset = 1'b0;

    // Contention: requester 0 wins the first tie, then alternation.
    req_valid = 2'b11; req_addr[0] = 6'd1; req_addr[1] = 6'd2;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("contend_ready", {30'd0, req_ready}, (k % 2 == 0) ? 32'd1 : 32'd2);
      tick();
    end
    req_valid = 2'b00;
    @(negedge clk);
    chk("idle_ready", {30'd0, req_ready}, 32'd0);
    chk("idle_mem_addr", {26'd0, mem_addr}, 32'd0);
    chk("idle_mem_wdata", mem_w_data, 32'd0);
    tick();

    // Single read of a preloaded word.
    do_req(1, 1'b1, 6'd5, 32'hDEADBEEF, "wr5_ready");
    do_req(0, 1'b0, 6'd5, 32'd0, "rd5_ready");

    // Write by requester 1, read-after-write by requester 0 next cycle.
    req_we[1] = 1'b1; req_addr[1] = 6'd63; req_wdata[1] = 32'h12345678;
    req_valid = 2'b10;
    @(negedge clk);
    chk("raw_wr_ready", {30'd0, req_ready}, 32'd2);
    chk("raw_wr_mem_addr", {26'd0, mem_addr}, 32'd63);
    tick();
    req_we[0] = 1'b0; req_addr[0] = 6'd63;
    req_valid = 2'b01;
    @(negedge clk);
    chk("raw_rd_ready", {30'd0, req_ready}, 32'd1);
    tick();
    req_valid = 2'b00;

    // Fill all 64 words back to back.
    req_we[1] = 1'b1; req_valid = 2'b10; nrdy = 0;
    for (int i = 0; i < 64; i++) begin
      req_addr[1]  = i[5:0];
      req_wdata[1] = 32'hA500_0000 | i;
      @(negedge clk);
      if (req_ready == 2'b10) nrdy++;
      tick();
    end
    req_valid = 2'b00;
    chk("fill_accepts", nrdy, 32'd64);

    // Clear with requester 0 pending.
    req_we[0] = 1'b0; req_addr[0] = 6'd7; req_valid = 2'b01;
    init_start = 1'b1;
    @(negedge clk);
    chk("start_ready", {30'd0, req_ready}, 32'd0);
    tick();
    init_start = 1'b0;
    sweep(0, busy_n, rdy_seen, bad);
    chk("clr_busy_cycles", busy_n, 32'd64);
    chk("clr_ready_seen", rdy_seen, 32'd0);
    chk("clr_port_bad", bad, 32'd0);
    chk("clr_post_ready", {30'd0, req_ready}, 32'd1);
    tick();
    req_valid = 2'b00;
    do_req(0, 1'b0, 6'd0, 32'd0, "clr_rd0_ready");
    do_req(1, 1'b0, 6'd63, 32'd0, "clr_rd63_ready");

    // Re-pulse mid-sweep does not extend it.
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    sweep(30, busy_n, rdy_seen, bad);
    chk("restart_busy_cycles", busy_n, 32'd64);
    chk("restart_port_bad", bad, 32'd0);
    tick();

    // Reset at sweep cycle 10 aborts the clear.
    do_req(1, 1'b1, 6'd9, 32'hCAFEF00D, "pre_rst_wr");
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    @(negedge clk);
    chk("rst_sweep_busy", {31'd0, init_busy}, 32'd1);
    tick();
    reset = 1'b1;
    @(negedge clk);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("abort_init_busy", {31'd0, init_busy}, 32'd0);
    chk("abort_mem_w_en", {31'd0, mem_w_en}, 32'd0);
    chk("abort_resp_valid", {30'd0, resp_valid}, 32'd0);
    tick();
    do_req(0, 1'b0, 6'd9, 32'd0, "post_rst_rd");

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester round-robin arbiter and sequencer for the 64-word × 32-bit single-port data memory. It shares the one memory port between requester 0 (CPU load/store unit) and requester 1 (loader/debug port). It performs at most one access per cycle and returns registered read data or a write acknowledgement to the winning requester. It also contains a clear sequencer that zeroes the whole memory on command, stalling both requesters while the sweep runs.

## Interface
- No parameters; fixed at 2 requesters, 6-bit address, 32-bit data.
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high; clock clk
- req_valid  in  2  per-requester request valid (bit i = requester i)
- req_we  in  2  per-requester write enable (1 = write, 0 = read)
- req_addr  in  2×6  per-requester word address
- req_wdata  in  2×32  per-requester write data
- req_ready  out  2  per-requester accept; request i is accepted when req_valid[i] && req_ready[i]
- resp_valid  out  2  one-cycle response pulse to requester i
- resp_rdata  out  32  read data (valid with resp_valid); shared by both requesters
- init_start  in  1  pulse: start clearing the entire memory
- init_busy  out  1  high while the clear sweep runs
- mem_w_en  out  1  memory write enable
- mem_addr  out  6  memory address
- mem_w_data  out  32  memory write data
- mem_r_data  in  32  memory read data (combinational from mem_addr)

## Operation
- State machine has two states: IDLE (arbitrating) and CLEAR (sweep).
- In IDLE, arbitration is combinational each cycle:
  - If only one req_valid is set, that requester is granted.
  - If both are set, the requester other than last_grant is granted.
  - last_grant updates to the granted index on every accept.
- req_ready[i] is high only for the granted requester, and only in IDLE with init_start low. At most one bit of req_ready is set; req_ready is never high for a requester without req_valid.
- Accepted write: mem_w_en=1, with mem_addr and mem_w_data taken from the winner in the same cycle. The memory updates at that clock edge.
- Accepted read: mem_w_en=0 and mem_addr = winner address. mem_r_data is captured into resp_rdata at that edge.
- Responses:
  - resp_valid[winner] is set for exactly the next cycle, for reads and writes alike.
  - On a write response, resp_rdata holds its previous value.
- Idle memory port: with no accept, mem_w_en=0, mem_addr=0, mem_w_data=0.
- CLEAR sweep:
  - init_start high in IDLE moves the block to CLEAR at the next edge; requests are not accepted in the init_start cycle.
  - In CLEAR, a 6-bit counter starting at 0 drives mem_addr, with mem_w_en=1 and mem_w_data=0.
  - The counter increments each cycle. After the write at address 63, the block returns to IDLE.
  - init_busy = (state == CLEAR).
- init_start during CLEAR is ignored; the sweep does not restart.
- Responses already pending from the cycle before CLEAR still issue normally.
- Requesters must hold req_* stable while req_valid is high and not accepted.

## Timing
- Reset values:
  - State IDLE, clear counter 0, last_grant=1 (requester 0 wins the first tie).
  - resp_valid=0, resp_rdata=0, init_busy=0.
  - req_ready follows its combinational rule (low unless req_valid).
  - mem_* outputs follow the idle rule.
- Reset mid-sweep aborts CLEAR immediately. Memory contents are whatever the memory's own reset leaves.
- Latency:
  - Accept to resp_valid: 1 cycle.
  - Throughput: 1 access per cycle, sustained.
  - Under continuous contention, grants alternate 0,1,0,1.
- Clear sweep:
  - Takes exactly 64 cycles of init_busy.
  - The first request can be accepted in the cycle after init_busy falls.
- A read in cycle N+1 of an address written in cycle N returns the new data.
- Address arithmetic is unsigned 6-bit. The sweep counter wraps 63→0 on exit, so the counter is always 0 on entry.

## Test plan
- Single read: preload mem[5]=0xDEADBEEF; requester 0 reads addr 5 → req_ready[0]=1 in that cycle; resp_valid[0] pulses next cycle with resp_rdata=0xDEADBEEF.
- Contention: both requesters valid for 4 cycles after reset, reading addrs 1 and 2 → grants go 0,1,0,1; resp_valid alternates the same way, one cycle delayed.
- Write then read: requester 1 writes 0x12345678 to addr 63; requester 0 reads addr 63 in the next cycle → resp_rdata=0x12345678; both write and read get a resp_valid pulse.
- Clear:
  - Fill memory with nonzero data, then pulse init_start while requester 0 is valid.
  - Required: req_ready stays 0 for the start cycle plus 64 busy cycles, and init_busy is high for exactly 64 cycles.
  - A read of any address afterwards returns 0, and the pending request is accepted in the first cycle after busy falls.
- Sweep robustness: a second init_start at sweep cycle 30 does not extend busy beyond 64 cycles. Asserting reset at sweep cycle 10 returns init_busy=0, and an idle mem_w_en=0 follows on the next cycle.
